// File: rtl/cpu_pkg.sv
// Shared encodings for the MIPS core pipeline: writeback source selects,
// load-type codes and default datapath widths.
package cpu_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_CNT_W  = 32;

  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_LOAD = 2'd1;
  localparam logic [1:0] WB_SEL_LINK = 2'd2;

  localparam logic [2:0] LD_NONE = 3'd0;
  localparam logic [2:0] LD_LB   = 3'd1;
  localparam logic [2:0] LD_LBU  = 3'd2;
  localparam logic [2:0] LD_LH   = 3'd3;
  localparam logic [2:0] LD_LHU  = 3'd4;
  localparam logic [2:0] LD_LW   = 3'd5;

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/halfword from a raw memory word and extends it;
// flags halfword/word accesses that are not naturally aligned.
module load_align
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [2:0]        load_type,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] data,
  output logic              misaligned
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v     = rdata[{addr_lo, 3'b000} +: 8];
    half_v     = addr_lo[1] ? rdata[16 +: 16] : rdata[0 +: 16];
    data       = rdata;
    misaligned = 1'b0;
    case (load_type)
      LD_LB:  data = {{(DATA_W-8){byte_v[7]}}, byte_v};
      LD_LBU: data = {{(DATA_W-8){1'b0}}, byte_v};
      LD_LH: begin
        data       = {{(DATA_W-16){half_v[15]}}, half_v};
        misaligned = addr_lo[0];
      end
      LD_LHU: begin
        data       = {{(DATA_W-16){1'b0}}, half_v};
        misaligned = addr_lo[0];
      end
      LD_LW:  misaligned = (addr_lo != 2'b00);
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register plus writeback mux; drives the register-file write
// port, the EX forwarding tap and a retired-instruction counter.
module mem_wb_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic              mem_rf_w,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [1:0]        mem_wb_sel,
  input  logic [2:0]        mem_load_type,
  input  logic [1:0]        mem_addr_lo,
  input  logic [DATA_W-1:0] mem_alu_res,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] mem_link_pc,
  output logic              rf_w,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              fwd_valid,
  output logic              align_err,
  output logic [CNT_W-1:0]  retired
);

  logic              wb_valid;
  logic              wb_rf_w;
  logic [ADDR_W-1:0] wb_waddr;
  logic [1:0]        wb_sel;
  logic [2:0]        wb_load_type;
  logic [1:0]        wb_addr_lo;
  logic [DATA_W-1:0] wb_alu_res;
  logic [DATA_W-1:0] wb_rdata;
  logic [DATA_W-1:0] wb_link_pc;

  logic [DATA_W-1:0] ld_data;
  logic              ld_mis;
  logic              count_en;

  // flush beats stall; stall freezes the whole WB slot, including its payload.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid     <= 1'b0;
      wb_rf_w      <= 1'b0;
      wb_waddr     <= '0;
      wb_sel       <= WB_SEL_ALU;
      wb_load_type <= LD_NONE;
      wb_addr_lo   <= 2'b00;
      wb_alu_res   <= '0;
      wb_rdata     <= '0;
      wb_link_pc   <= '0;
    end else if (flush) begin
      wb_valid <= 1'b0;
    end else if (!stall) begin
      wb_valid     <= mem_valid;
      wb_rf_w      <= mem_rf_w;
      wb_waddr     <= mem_waddr;
      wb_sel       <= mem_wb_sel;
      wb_load_type <= mem_load_type;
      wb_addr_lo   <= mem_addr_lo;
      wb_alu_res   <= mem_alu_res;
      wb_rdata     <= mem_rdata;
      wb_link_pc   <= mem_link_pc;
    end
  end

  load_align #(.DATA_W(DATA_W)) u_load_align (
    .load_type  (wb_load_type),
    .addr_lo    (wb_addr_lo),
    .rdata      (wb_rdata),
    .data       (ld_data),
    .misaligned (ld_mis)
  );

  always_comb begin
    case (wb_sel)
      WB_SEL_LOAD: wdata = ld_data;
      WB_SEL_LINK: wdata = wb_link_pc;
      default:     wdata = wb_alu_res;
    endcase
  end

  assign waddr     = wb_waddr;
  assign align_err = wb_valid & ld_mis;
  assign rf_w      = wb_valid & wb_rf_w & (wb_waddr != '0) & ~align_err;
  assign fwd_valid = rf_w;

  // An instruction retires when it leaves WB; a stalled one is counted only on
  // the edge it finally moves on, and a flush during stall drops it uncounted.
  assign count_en = wb_valid & ~align_err & ~stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retired <= '0;
    end else if (count_en) begin
      retired <= retired + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: a vector table streamed back-to-back, then
// hand-written stall/flush/reset sequences.
module tb_mem_wb_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush;
  logic        mem_valid, mem_rf_w;
  logic [4:0]  mem_waddr;
  logic [1:0]  mem_wb_sel;
  logic [2:0]  mem_load_type;
  logic [1:0]  mem_addr_lo;
  logic [31:0] mem_alu_res, mem_rdata, mem_link_pc;
  logic        rf_w, fwd_valid, align_err;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] retired;

  mem_wb_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .mem_valid     (mem_valid),
    .mem_rf_w      (mem_rf_w),
    .mem_waddr     (mem_waddr),
    .mem_wb_sel    (mem_wb_sel),
    .mem_load_type (mem_load_type),
    .mem_addr_lo   (mem_addr_lo),
    .mem_alu_res   (mem_alu_res),
    .mem_rdata     (mem_rdata),
    .mem_link_pc   (mem_link_pc),
    .rf_w          (rf_w),
    .waddr         (waddr),
    .wdata         (wdata),
    .fwd_valid     (fwd_valid),
    .align_err     (align_err),
    .retired       (retired)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic        rf_w;
    logic [4:0]  waddr;
    logic [1:0]  sel;
    logic [2:0]  lt;
    logic [1:0]  lo;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] link;
    logic        e_rf_w;
    logic        e_err;
    logic        chk_wdata;
    logic [31:0] e_wdata;
    logic        counted;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  logic [31:0] exp_q[$];
  int tests = 0;
  int fails = 0;
  logic [31:0] exp_ret;
  logic        pending;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    mem_valid = 1'b0; mem_rf_w = 1'b0; mem_waddr = '0; mem_wb_sel = WB_SEL_ALU;
    mem_load_type = LD_NONE; mem_addr_lo = 2'b00;
    mem_alu_res = '0; mem_rdata = '0; mem_link_pc = '0;
  endtask

  task automatic drive_alu(input logic [4:0] a, input logic [31:0] v);
    mem_valid = 1'b1; mem_rf_w = 1'b1; mem_waddr = a; mem_wb_sel = WB_SEL_ALU;
    mem_load_type = LD_NONE; mem_addr_lo = 2'b00;
    mem_alu_res = v; mem_rdata = '0; mem_link_pc = '0;
  endtask

  // retired advances on the edge that moves the WB instruction out
  task automatic edge_count(input logic next_pending);
    step();
    if (pending) exp_ret = exp_ret + 1;
    pending = next_pending;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 5'd8,  WB_SEL_ALU,  LD_NONE, 2'd0, 32'h0000_1234, 32'h0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h0000_1234, 1'b1};
    vecs[1]  = '{1'b1, 5'd9,  WB_SEL_LOAD, LD_LB,   2'd3, 32'h0,         32'h80FF_0000, 32'h0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FF80, 1'b1};
    vecs[2]  = '{1'b1, 5'd9,  WB_SEL_LOAD, LD_LBU,  2'd3, 32'h0,         32'h80FF_0000, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0000_0080, 1'b1};
    vecs[3]  = '{1'b1, 5'd10, WB_SEL_LOAD, LD_LH,   2'd1, 32'h0,         32'h80FF_0000, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0};
    vecs[4]  = '{1'b1, 5'd11, WB_SEL_LOAD, LD_LHU,  2'd2, 32'h0,         32'hBEEF_0000, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0000_BEEF, 1'b1};
    vecs[5]  = '{1'b1, 5'd31, WB_SEL_LINK, LD_NONE, 2'd0, 32'h0,         32'h0, 32'h0040_0008, 1'b1, 1'b0, 1'b1, 32'h0040_0008, 1'b1};
    vecs[6]  = '{1'b1, 5'd0,  WB_SEL_LINK, LD_NONE, 2'd0, 32'h0,         32'h0, 32'h0040_0008, 1'b0, 1'b0, 1'b1, 32'h0040_0008, 1'b1};
    vecs[7]  = '{1'b1, 5'd12, WB_SEL_LOAD, LD_LW,   2'd2, 32'h0,         32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0};
    vecs[8]  = '{1'b1, 5'd12, WB_SEL_LOAD, LD_LW,   2'd0, 32'h0,         32'hDEAD_BEEF, 32'h0, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1};
    vecs[9]  = '{1'b1, 5'd13, WB_SEL_LOAD, LD_LH,   2'd2, 32'h0,         32'h8001_1234, 32'h0, 1'b1, 1'b0, 1'b1, 32'hFFFF_8001, 1'b1};
    vecs[10] = '{1'b1, 5'd14, WB_SEL_LOAD, LD_LB,   2'd1, 32'h0,         32'h0000_7F00, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0000_007F, 1'b1};
    vecs[11] = '{1'b1, 5'd15, 2'd3,        LD_NONE, 2'd0, 32'h0000_CAFE, 32'h1111_1111, 32'h2, 1'b1, 1'b0, 1'b1, 32'h0000_CAFE, 1'b1};
    vecs[12] = '{1'b0, 5'd16, WB_SEL_ALU,  LD_NONE, 2'd0, 32'h0000_0042, 32'h0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0000_0042, 1'b1};
    vecs[13] = '{1'b1, 5'd5,  WB_SEL_LOAD, LD_LBU,  2'd0, 32'h0,         32'h1234_5678, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0000_0078, 1'b1};

    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    drive_idle();
    exp_ret = '0; pending = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rf_w", {31'b0, rf_w}, 32'h0);
    check("reset_fwd", {31'b0, fwd_valid}, 32'h0);
    check("reset_align", {31'b0, align_err}, 32'h0);
    check("reset_waddr", {27'b0, waddr}, 32'h0);
    check("reset_wdata", wdata, 32'h0);
    check("reset_retired", retired, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // streamed vector table
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      mem_valid = 1'b1; mem_rf_w = vecs[i].rf_w; mem_waddr = vecs[i].waddr;
      mem_wb_sel = vecs[i].sel; mem_load_type = vecs[i].lt; mem_addr_lo = vecs[i].lo;
      mem_alu_res = vecs[i].alu; mem_rdata = vecs[i].rdata; mem_link_pc = vecs[i].link;
      if (vecs[i].chk_wdata) exp_q.push_back(vecs[i].e_wdata);
      edge_count(vecs[i].counted);
      check($sformatf("v%0d_rf_w", i), {31'b0, rf_w}, {31'b0, vecs[i].e_rf_w});
      check($sformatf("v%0d_fwd", i), {31'b0, fwd_valid}, {31'b0, vecs[i].e_rf_w});
      check($sformatf("v%0d_align", i), {31'b0, align_err}, {31'b0, vecs[i].e_err});
      check($sformatf("v%0d_waddr", i), {27'b0, waddr}, {27'b0, vecs[i].waddr});
      check($sformatf("v%0d_retired", i), retired, exp_ret);
      if (vecs[i].chk_wdata) check($sformatf("v%0d_wdata", i), wdata, exp_q.pop_front());
    end
    @(negedge clk);
    drive_idle();
    edge_count(1'b0);
    check("drain_retired", retired, exp_ret);
    check("drain_rf_w", {31'b0, rf_w}, 32'h0);

    // stall for three cycles: outputs frozen, one count when released
    @(negedge clk);
    drive_alu(5'd3, 32'h0000_00AA);
    edge_count(1'b1);
    check("stall_pre_wdata", wdata, 32'h0000_00AA);
    @(negedge clk);
    stall = 1'b1;
    drive_alu(5'd4, 32'h0000_0055);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("stall%0d_rf_w", k), {31'b0, rf_w}, 32'h1);
      check($sformatf("stall%0d_waddr", k), {27'b0, waddr}, 32'd3);
      check($sformatf("stall%0d_wdata", k), wdata, 32'h0000_00AA);
      check($sformatf("stall%0d_retired", k), retired, exp_ret);
    end
    @(negedge clk);
    stall = 1'b0;
    drive_idle();
    edge_count(1'b0);
    check("stall_post_retired", retired, exp_ret);
    check("stall_post_rf_w", {31'b0, rf_w}, 32'h0);

    // stall together with flush: the held instruction vanishes uncounted
    @(negedge clk);
    drive_alu(5'd6, 32'h0000_0066);
    edge_count(1'b1);
    check("sf_pre_rf_w", {31'b0, rf_w}, 32'h1);
    @(negedge clk);
    stall = 1'b1; flush = 1'b1;
    drive_alu(5'd7, 32'h0000_0077);
    step();
    pending = 1'b0;
    check("sf_rf_w", {31'b0, rf_w}, 32'h0);
    check("sf_fwd", {31'b0, fwd_valid}, 32'h0);
    check("sf_retired", retired, exp_ret);
    @(negedge clk);
    stall = 1'b0; flush = 1'b0;
    drive_idle();
    edge_count(1'b0);
    check("sf_after_retired", retired, exp_ret);

    // flush alone: the outgoing instruction still retires, a bubble enters
    @(negedge clk);
    drive_alu(5'd9, 32'h0000_0099);
    edge_count(1'b1);
    @(negedge clk);
    flush = 1'b1;
    drive_alu(5'd10, 32'h0000_0100);
    edge_count(1'b0);
    check("flush_rf_w", {31'b0, rf_w}, 32'h0);
    check("flush_retired", retired, exp_ret);
    @(negedge clk);
    flush = 1'b0;
    drive_idle();

    // asynchronous reset mid-cycle while a write is being issued
    @(negedge clk);
    drive_alu(5'd7, 32'h0000_0777);
    edge_count(1'b1);
    check("rst_pre_rf_w", {31'b0, rf_w}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    exp_ret = '0; pending = 1'b0;
    check("rst_rf_w", {31'b0, rf_w}, 32'h0);
    check("rst_wdata", wdata, 32'h0);
    check("rst_retired", retired, exp_ret);
    @(negedge clk);
    rst = 1'b1;
    drive_alu(5'd12, 32'h0000_1234);
    edge_count(1'b1);
    check("post_rst_rf_w", {31'b0, rf_w}, 32'h1);
    check("post_rst_waddr", {27'b0, waddr}, 32'd12);
    check("post_rst_wdata", wdata, 32'h0000_1234);
    check("post_rst_retired0", retired, exp_ret);
    @(negedge clk);
    drive_idle();
    edge_count(1'b0);
    check("post_rst_retired1", retired, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
